// File: rtl/audio_in.sv
// I2S receiver: brings the codec's bit clock, word clock and data into the clk
// domain, deserialises one word per channel and commits each left/right pair to
// the outputs together once the right word has been captured.
module audio_in #(
    parameter int unsigned DW        = 16,
    parameter int unsigned MIN_RATIO = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i2s_bclk,
    input  logic          i2s_lrclk,
    input  logic          i2s_data,
    output logic [DW-1:0] left_out,
    output logic [DW-1:0] right_out,
    output logic          sample_valid,
    output logic          frame_err
);

    localparam int unsigned     CntW    = $clog2(DW + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(DW - 1);

    // The bit strobe needs bclk high and low for at least one clk each, so
    // ratios below 2 cannot work at all; MIN_RATIO records the supported floor.
    if (MIN_RATIO < 2) begin : g_ratio_unsupported
    end

    typedef enum logic [1:0] {
        StSync,
        StShift,
        StHold
    } state_e;

    // ------------------------------------------------------------------
    // Synchronisers
    // ------------------------------------------------------------------
    logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
    logic lr_s1_q, lr_s2_q;
    logic data_s1_q, data_s2_q;
    logic bit_stb;

    // Two flops per asynchronous input, plus a third on bclk for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            bclk_s1_q <= 1'b0;
            bclk_s2_q <= 1'b0;
            bclk_s3_q <= 1'b0;
            lr_s1_q   <= 1'b0;
            lr_s2_q   <= 1'b0;
            data_s1_q <= 1'b0;
            data_s2_q <= 1'b0;
        end else begin
            bclk_s1_q <= i2s_bclk;
            bclk_s2_q <= bclk_s1_q;
            bclk_s3_q <= bclk_s2_q;
            lr_s1_q   <= i2s_lrclk;
            lr_s2_q   <= lr_s1_q;
            data_s1_q <= i2s_data;
            data_s2_q <= data_s1_q;
        end
    end

    // One-clk strobe on each synchronised bclk rising edge.
    assign bit_stb = bclk_s2_q & ~bclk_s3_q;

    // ------------------------------------------------------------------
    // Word framing FSM
    // ------------------------------------------------------------------
    state_e          state_q, state_d;
    logic            lr_prev_q;
    logic            lr_change;
    logic [CntW-1:0] bit_cnt_q;
    logic            last_bit;
    logic            word_start;
    logic            shift_en;
    logic            word_done;
    logic            trunc;

    // lrclk is only ever compared at bit strobes, never between them.
    assign lr_change = bit_stb & (lr_s2_q != lr_prev_q);
    assign last_bit  = (bit_cnt_q == LastBit);

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StSync: begin
                // Only a 1->0 change (left word start) gets us into lock.
                if (lr_change && !lr_s2_q) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (lr_change) begin
                    state_d = StShift;
                end else if (bit_stb && last_bit) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (lr_change) begin
                    state_d = StShift;
                end
            end
            default: state_d = StSync;
        endcase
    end

    // FSM outputs: datapath controls decoded from the current state.
    always_comb begin
        word_start = 1'b0;
        shift_en   = 1'b0;
        trunc      = 1'b0;
        case (state_q)
            StSync: begin
                word_start = lr_change & ~lr_s2_q;
            end
            StShift: begin
                // A change here means the word in progress is short.
                word_start = lr_change;
                trunc      = lr_change;
                shift_en   = bit_stb & ~lr_change;
            end
            StHold: begin
                word_start = lr_change;
            end
            default: begin
                word_start = 1'b0;
            end
        endcase
    end

    assign word_done = shift_en & last_bit;

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    logic [DW-1:0] shift_q;
    logic          word_ch_q;
    logic          done_q;

    // Shift register, bit counter, word channel and lrclk history.
    always_ff @(posedge clk) begin
        if (reset) begin
            lr_prev_q <= 1'b0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            word_ch_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= word_done;
            if (bit_stb) begin
                lr_prev_q <= lr_s2_q;
            end
            // The strobe that starts a word is the I2S delay bit: not shifted.
            if (word_start) begin
                bit_cnt_q <= '0;
                word_ch_q <= lr_s2_q;
            end else if (shift_en) begin
                shift_q   <= {shift_q[DW-2:0], data_s2_q};
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Holding register and commit
    // ------------------------------------------------------------------
    logic [DW-1:0] left_hold_q;
    logic          left_valid_q;
    logic [DW-1:0] left_out_q;
    logic [DW-1:0] right_out_q;
    logic          sample_valid_q;
    logic          frame_err_q;

    // Completed words land one clk after their last bit. word_ch_q and shift_q
    // still describe that word, since the FSM is in HOLD until the next change.
    always_ff @(posedge clk) begin
        if (reset) begin
            left_hold_q    <= '0;
            left_valid_q   <= 1'b0;
            left_out_q     <= '0;
            right_out_q    <= '0;
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            sample_valid_q <= 1'b0;
            frame_err_q    <= 1'b0;
            if (trunc) begin
                frame_err_q <= 1'b1;
                if (!word_ch_q) begin
                    left_valid_q <= 1'b0;
                end
            end
            if (done_q) begin
                if (!word_ch_q) begin
                    left_hold_q  <= shift_q;
                    left_valid_q <= 1'b1;
                end else if (left_valid_q) begin
                    left_out_q     <= left_hold_q;
                    right_out_q    <= shift_q;
                    sample_valid_q <= 1'b1;
                    left_valid_q   <= 1'b0;
                end else begin
                    // Right word with no matching left word: drop it.
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    assign left_out     = left_out_q;
    assign right_out    = right_out_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_audio_in.sv
// Bench for audio_in: drives I2S frames with a bclk asynchronous to clk and
// scoreboards every sample_valid / frame_err pulse, including its cycle.
`timescale 1ns/1ps
module tb_audio_in;

    localparam int DW      = 16;
    localparam int KNone   = 0;
    localparam int KCommit = 1;
    localparam int KErr    = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          i2s_bclk;
    logic          i2s_lrclk;
    logic          i2s_data;
    logic [DW-1:0] left_out;
    logic [DW-1:0] right_out;
    logic          sample_valid;
    logic          frame_err;

    audio_in #(
        .DW       (DW),
        .MIN_RATIO(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_data    (i2s_data),
        .left_out    (left_out),
        .right_out   (right_out),
        .sample_valid(sample_valid),
        .frame_err   (frame_err)
    );

    // 50 MHz system clock.
    always #10 clk = ~clk;

    typedef struct {
        int          kind;
        logic [15:0] l;
        logic [15:0] r;
        int          idx;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        arm_e;
    exp_t        mon_e;
    int          neg_cnt  = 0;
    int          arm_seq  = 0;
    int          arm_seen = 0;
    int          arm_kind;
    int          arm_off;
    logic [15:0] arm_l;
    logic [15:0] arm_r;
    int          ck_seq   = 0;
    int          ck_seen  = 0;
    logic [15:0] ck_l;
    logic [15:0] ck_r;
    string       ck_name;
    bit          fin_req  = 1'b0;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        prev_sv  = 1'b0;
    logic        prev_fe  = 1'b0;
    realtime     half_ns  = 162.76;

    // Expected pulse lands N negedges after the first clk edge that sees bclk high.
    always @(posedge clk) begin
        if (arm_seq != arm_seen) begin
            arm_e.kind = arm_kind;
            arm_e.l    = arm_l;
            arm_e.r    = arm_r;
            arm_e.idx  = neg_cnt + arm_off;
            exp_q.push_back(arm_e);
            arm_seen   = arm_seq;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: all comparisons happen here, on the falling clk edge.
    always @(negedge clk) begin
        neg_cnt++;
        while (exp_q.size() > 0 && exp_q[0].idx < neg_cnt) begin
            n_checks++;
            $display("FAIL missing_pulse: no pulse at cycle %0d, expected kind %0d",
                     exp_q[0].idx, exp_q[0].kind);
            void'(exp_q.pop_front());
        end
        if (sample_valid || frame_err) begin
            check("pulse_rule", {29'd0, sample_valid & frame_err, sample_valid & prev_sv,
                                 frame_err & prev_fe}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_pulse: sample_valid=%0b frame_err=%0b at cycle %0d, none expected",
                         sample_valid, frame_err, neg_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_kind", sample_valid ? KCommit : KErr, mon_e.kind);
                check("pulse_cycle", neg_cnt, mon_e.idx);
                if (sample_valid && mon_e.kind == KCommit) begin
                    check("commit_left", {16'd0, left_out}, {16'd0, mon_e.l});
                    check("commit_right", {16'd0, right_out}, {16'd0, mon_e.r});
                end
            end
        end
        prev_sv = sample_valid;
        prev_fe = frame_err;
        if (ck_seq != ck_seen) begin
            check({ck_name, "_left"}, {16'd0, left_out}, {16'd0, ck_l});
            check({ck_name, "_right"}, {16'd0, right_out}, {16'd0, ck_r});
            ck_seen = ck_seq;
        end
        if (fin_req) begin
            check("queue_empty", exp_q.size(), 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $finish;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    // Put bclk edges at a fixed offset from clk so they never coincide.
    task automatic realign();
        @(negedge clk);
        #3.3;
    endtask

    task automatic checkpoint(input string name, input logic [15:0] l, input logic [15:0] r);
        #1;
        ck_name = name;
        ck_l    = l;
        ck_r    = r;
        ck_seq++;
        @(negedge clk);
        @(negedge clk);
        realign();
    endtask

    // One bclk period: data and lrclk change on the falling edge.
    task automatic slot(input logic lr, input logic d, input int akind, input int aoff,
                        input logic [15:0] al, input logic [15:0] ar);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_data  = d;
        #(half_ns);
        i2s_bclk = 1'b1;
        if (akind != KNone) begin
            arm_kind = akind;
            arm_off  = aoff;
            arm_l    = al;
            arm_r    = ar;
            arm_seq++;
        end
        #(half_ns);
    endtask

    // Slot 0 is the delay bit; slots 1..16 carry the word MSB first.
    task automatic send_word(input logic ch, input logic [15:0] w, input int nslots,
                             input int start_kind, input int lsb_kind, input logic [15:0] cl);
        for (int k = 0; k < nslots; k++) begin
            logic d;
            int   kk;
            int   ko;
            d  = (k >= 1 && k <= 16) ? w[16-k] : 1'b0;
            kk = KNone;
            ko = 0;
            if (k == 0) begin
                kk = start_kind;
                ko = 3;
            end else if (k == 16) begin
                kk = lsb_kind;
                ko = 4;
            end
            slot(ch, d, kk, ko, cl, w);
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        send_word(1'b0, l, 32, KNone, KNone, 16'h0);
        send_word(1'b1, r, 32, KNone, KCommit, l);
    endtask

    initial begin
        reset     = 1'b1;
        i2s_bclk  = 1'b0;
        i2s_lrclk = 1'b0;
        i2s_data  = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        checkpoint("reset", 16'h0000, 16'h0000);

        // Start in the middle of a right word, then one full frame.
        for (int k = 0; k < 20; k++) slot(1'b1, k[0], KNone, 0, 16'h0, 16'h0);
        frame(16'h5555, 16'hAAAA);
        checkpoint("mid_start", 16'h5555, 16'hAAAA);

        frame(16'h8001, 16'h7FFE);
        checkpoint("basic", 16'h8001, 16'h7FFE);

        frame(16'h1234, 16'hABCD);
        frame(16'h0000, 16'hFFFF);
        frame(16'h7FFF, 16'h8000);
        checkpoint("three_frames", 16'h7FFF, 16'h8000);

        // Left cut after 10 data bits; the right word then has no partner.
        send_word(1'b0, 16'hF0F0, 11, KNone, KNone, 16'h0);
        send_word(1'b1, 16'h0F0F, 32, KErr, KErr, 16'h0);
        checkpoint("truncated", 16'h7FFF, 16'h8000);

        // One-clk reset in the middle of the left word.
        fork
            begin
                #(half_ns * 2 * 8);
                @(negedge clk);
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
            end
        join_none
        send_word(1'b0, 16'h1111, 32, KNone, KNone, 16'h0);
        send_word(1'b1, 16'h2222, 32, KNone, KNone, 16'h0);
        checkpoint("reset_pulse", 16'h0000, 16'h0000);
        frame(16'h3333, 16'h4444);
        checkpoint("after_reset", 16'h3333, 16'h4444);

        // clk = 4 x bclk.
        half_ns = 40.0;
        frame(16'hC3A5, 16'h5A3C);

        // bclk parked: nothing more may happen.
        repeat (100) @(negedge clk);
        checkpoint("hold", 16'hC3A5, 16'h5A3C);
        #1;
        fin_req = 1'b1;
    end

endmodule
